// File: rtl/tut3_verilog_regincr_pkg.sv
//------------------------------------------------------------------------
// tut3_verilog_regincr_pkg
//------------------------------------------------------------------------
// Shared definitions for the registered-incrementer result queue.
//   c_msg_nbits     : width of a result message (registered-incrementer output)
//   c_default_depth : default number of queue entries
//   msg_t           : message type, c_msg_nbits wide
//   count_nbits()   : width of an occupancy counter for a given depth
//------------------------------------------------------------------------

package tut3_verilog_regincr_pkg;

  localparam int unsigned c_msg_nbits     = 9;
  localparam int unsigned c_default_depth = 4;

  typedef logic [c_msg_nbits-1:0] msg_t;

  // Occupancy runs 0..depth inclusive, so one bit more than the pointer.
  function automatic int unsigned count_nbits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tut3_verilog_regincr_queue_dpath.sv
//------------------------------------------------------------------------
// tut3_verilog_regincr_queue_dpath
//------------------------------------------------------------------------
// Storage for the result queue: a register array with one synchronous
// write port and one combinational read port. Entries are not reset;
// validity is tracked by the control logic in the top level.
//
// Ports:
//   clk     : clock, writes on rising edge
//   wr_en   : write enable
//   wr_addr : write entry index
//   wr_data : write data
//   rd_addr : read entry index
//   rd_data : entry contents at rd_addr (combinational)
//------------------------------------------------------------------------

module tut3_verilog_regincr_queue_dpath
  import tut3_verilog_regincr_pkg::*;
#(
  parameter int unsigned p_nbits = c_msg_nbits,
  parameter int unsigned p_depth = c_default_depth
)(
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(p_depth)-1:0] wr_addr,
  input  logic [p_nbits-1:0]         wr_data,
  input  logic [$clog2(p_depth)-1:0] rd_addr,
  output logic [p_nbits-1:0]         rd_data
);

  localparam int unsigned c_addr_nbits = $clog2(p_depth);

  logic [p_nbits-1:0] entry_data [p_depth];

  genvar gi;
  generate
    for (gi = 0; gi < p_depth; gi = gi + 1) begin : g_entry
      logic [p_nbits-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == c_addr_nbits'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entry_data[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = entry_data[rd_addr];

endmodule

// File: rtl/tut3_verilog_regincr_result_queue.sv
//------------------------------------------------------------------------
// tut3_verilog_regincr_result_queue
//------------------------------------------------------------------------
// FIFO that captures results from the registered-incrementer stage. The
// producer has no back-pressure: a result arriving while the queue is full
// (and nothing leaves that cycle) is dropped and the sticky overflow flag
// is raised until the next reset.
//
// Build option:
//   TUT3_VERILOG_REGINCR_RESULT_QUEUE_BYPASS_EN
//     When defined, an incoming result is presented on deq_* in the same
//     cycle while the queue is empty. If the consumer takes it, it is not
//     stored; otherwise it is stored as usual. When undefined, there is no
//     combinational path from enq_* to deq_*.
//
// Ports:
//   clk      : clock, all state updates on rising edge
//   reset    : synchronous, active-high reset
//   enq_val  : a result is present this cycle
//   enq_msg  : result value
//   deq_val  : head entry valid
//   deq_rdy  : consumer accepts the head
//   deq_msg  : head value (0 when deq_val=0)
//   count    : current occupancy, 0..p_depth
//   overflow : sticky, at least one result was dropped
//------------------------------------------------------------------------

module tut3_verilog_regincr_result_queue
  import tut3_verilog_regincr_pkg::*;
#(
  parameter int unsigned p_nbits = c_msg_nbits,
  parameter int unsigned p_depth = c_default_depth
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  input  logic [p_nbits-1:0]       enq_msg,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic [p_nbits-1:0]       deq_msg,
  output logic [$clog2(p_depth):0] count,
  output logic                     overflow
);

  localparam int unsigned c_addr_nbits  = $clog2(p_depth);
  localparam int unsigned c_count_nbits = count_nbits(p_depth);
  localparam logic [c_count_nbits-1:0] c_full = c_count_nbits'(p_depth);

  logic [c_addr_nbits-1:0]  wr_ptr_reg,   wr_ptr_next;
  logic [c_addr_nbits-1:0]  rd_ptr_reg,   rd_ptr_next;
  logic [c_count_nbits-1:0] count_reg,    count_next;
  logic                     overflow_reg, overflow_next;

  logic               not_empty;
  logic               full;
  logic               stored_fire;
  logic               bypass;
  logic               enq_accept;
  logic               enq_drop;
  logic [p_nbits-1:0] rd_data;

  assign not_empty   = (count_reg != '0);
  assign full        = (count_reg == c_full);
  // A dequeue only consumes storage when the head comes from the array.
  assign stored_fire = not_empty && deq_rdy;

`ifdef TUT3_VERILOG_REGINCR_RESULT_QUEUE_BYPASS_EN
  // Empty queue: the incoming result is shown directly; if the consumer
  // takes it this cycle it never touches storage.
  assign bypass  = !not_empty && enq_val && deq_rdy;
  assign deq_val = not_empty || enq_val;
  assign deq_msg = not_empty ? rd_data : (enq_val ? enq_msg : '0);
`else
  assign bypass  = 1'b0;
  assign deq_val = not_empty;
  assign deq_msg = not_empty ? rd_data : '0;
`endif

  // A full queue still accepts when the head leaves in the same cycle.
  assign enq_accept = enq_val && !bypass && (!full || stored_fire);
  assign enq_drop   = enq_val && full && !stored_fire;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg || enq_drop;

    // Pointer width equals log2(depth), so natural overflow is the wrap.
    if (enq_accept) begin
      wr_ptr_next = wr_ptr_reg + c_addr_nbits'(1);
    end
    if (stored_fire) begin
      rd_ptr_next = rd_ptr_reg + c_addr_nbits'(1);
    end

    case ({enq_accept, stored_fire})
      2'b10:   count_next = count_reg + c_count_nbits'(1);
      2'b01:   count_next = count_reg - c_count_nbits'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage writes are gated by enq_accept, which is only a don't-care
  // during reset because the pointers and count are cleared anyway.
  tut3_verilog_regincr_queue_dpath #(
    .p_nbits (p_nbits),
    .p_depth (p_depth)
  ) dpath (
    .clk     (clk),
    .wr_en   (enq_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (enq_msg),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_tut3_verilog_regincr_result_queue.sv
//------------------------------------------------------------------------
// tb_tut3_verilog_regincr_result_queue
//------------------------------------------------------------------------
// Directed testbench for the result queue (default depth 4, width 9).
//------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_tut3_verilog_regincr_result_queue;

  logic       clk;
  logic       reset;
  logic       enq_val;
  logic [8:0] enq_msg;
  logic       deq_val;
  logic       deq_rdy;
  logic [8:0] deq_msg;
  logic [2:0] count;
  logic       overflow;

  int n_total;
  int n_passed;

  tut3_verilog_regincr_result_queue dut (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (enq_val),
    .enq_msg  (enq_msg),
    .deq_val  (deq_val),
    .deq_rdy  (deq_rdy),
    .deq_msg  (deq_msg),
    .count    (count),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) begin
      n_passed = n_passed + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enqueue one value with the consumer stalled.
  task automatic enq(input logic [8:0] v);
    enq_val = 1'b1;
    enq_msg = v;
    deq_rdy = 1'b0;
    step();
    enq_val = 1'b0;
    $display("enq 0x%03h count=%0d overflow=%0b", v, count, overflow);
  endtask

  // Check the head, then dequeue it.
  task automatic deq_expect(input string tag, input logic [8:0] v);
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    #1;
    check({tag, "_val"}, 32'(deq_val), 32'd1);
    check({tag, "_msg"}, 32'(deq_msg), 32'(v));
    step();
    deq_rdy = 1'b0;
    $display("deq 0x%03h count=%0d overflow=%0b", v, count, overflow);
  endtask

  initial begin
    n_total  = 0;
    n_passed = 0;

    // Reset held two cycles with a result present.
    reset   = 1'b1;
    enq_val = 1'b1;
    enq_msg = 9'h055;
    deq_rdy = 1'b0;
    step();
    step();
    check("rst_deq_val", 32'(deq_val), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_deq_msg", 32'(deq_msg), 32'd0);
    reset   = 1'b0;
    enq_val = 1'b0;
    step();
    check("idle_count", 32'(count), 32'd0);

    // In-order drain.
    enq(9'h001);
    enq(9'h002);
    enq(9'h003);
    check("order_count", 32'(count), 32'd3);
    deq_expect("order_0", 9'h001);
    deq_expect("order_1", 9'h002);
    deq_expect("order_2", 9'h003);
    check("order_empty_count", 32'(count), 32'd0);
    check("order_empty_val", 32'(deq_val), 32'd0);
    check("order_empty_msg", 32'(deq_msg), 32'd0);

    // Overflow: fifth result dropped, contents untouched.
    for (int i = 0; i < 4; i++) enq(9'h010 + 9'(i));
    check("ovf_full_count", 32'(count), 32'd4);
    check("ovf_before", 32'(overflow), 32'd0);
    enq(9'h1FF);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) deq_expect($sformatf("ovf_drain_%0d", i), 9'h010 + 9'(i));
    check("ovf_drain_count", 32'(count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Clear overflow, then full with simultaneous enqueue and dequeue.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) enq(9'h020 + 9'(i));
    enq_val = 1'b1;
    enq_msg = 9'h0AA;
    deq_rdy = 1'b1;
    #1;
    check("simul_head", 32'(deq_msg), 32'h020);
    step();
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    $display("enq 0x0aa + deq 0x020 count=%0d overflow=%0b", count, overflow);
    check("simul_count", 32'(count), 32'd4);
    check("simul_overflow", 32'(overflow), 32'd0);
    deq_expect("simul_d0", 9'h021);
    deq_expect("simul_d1", 9'h022);
    deq_expect("simul_d2", 9'h023);
    deq_expect("simul_d3", 9'h0AA);
    check("simul_empty", 32'(count), 32'd0);

    // Wrap: ten enqueue/dequeue pairs crossing the 0x0FF/0x100 boundary.
    for (int i = 0; i < 10; i++) begin
      enq(9'h0FE + 9'(i));
      check($sformatf("wrap_count_%0d", i), 32'(count), 32'd1);
      deq_expect($sformatf("wrap_%0d", i), 9'h0FE + 9'(i));
    end
    check("wrap_empty", 32'(count), 32'd0);

    // Empty queue, result arrives with consumer ready.
    enq_val = 1'b1;
    enq_msg = 9'h0AB;
    deq_rdy = 1'b1;
    #1;
`ifdef TUT3_VERILOG_REGINCR_RESULT_QUEUE_BYPASS_EN
    check("byp_same_val", 32'(deq_val), 32'd1);
    check("byp_same_msg", 32'(deq_msg), 32'h0AB);
    step();
    enq_val = 1'b0;
    $display("bypass 0x0ab count=%0d", count);
    check("byp_count", 32'(count), 32'd0);
    check("byp_after_val", 32'(deq_val), 32'd0);
`else
    check("byp_same_val", 32'(deq_val), 32'd0);
    check("byp_same_msg", 32'(deq_msg), 32'd0);
    step();
    enq_val = 1'b0;
    $display("enq 0x0ab count=%0d", count);
    check("byp_count", 32'(count), 32'd1);
    check("byp_next_msg", 32'(deq_msg), 32'h0AB);
    step();
    check("byp_drained", 32'(count), 32'd0);
`endif
    deq_rdy = 1'b0;

    // Mid-operation reset with two entries stored; reset beats enq/deq.
    enq(9'h030);
    enq(9'h031);
    check("midrst_pre_count", 32'(count), 32'd2);
    reset   = 1'b1;
    enq_val = 1'b1;
    enq_msg = 9'h032;
    deq_rdy = 1'b1;
    step();
    $display("reset with 2 stored count=%0d", count);
    check("midrst_count", 32'(count), 32'd0);
    reset   = 1'b0;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    #1;
    check("midrst_val", 32'(deq_val), 32'd0);
    check("midrst_msg", 32'(deq_msg), 32'd0);
    step();
    check("midrst_after_count", 32'(count), 32'd0);
    check("midrst_after_val", 32'(deq_val), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/tut3_verilog_regincr_result_queue.md
TUT3_VERILOG_REGINCR_RESULT_QUEUE -- requirements
Module: tut3_verilog_regincr_result_queue

Interface
REQ-001 The block SHALL have parameter p_nbits, default 9, giving the message width, matching the registered-incrementer output.
REQ-002 The block SHALL have parameter p_depth, default 4, giving the entry count; legal values are powers of two, minimum 2.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset: synchronous, active-high.
REQ-005 The block SHALL have port enq_val, input, 1 bit, meaning a result is present this cycle; there is no back-pressure to the producer.
REQ-006 The block SHALL have port enq_msg, input, p_nbits, the result value from the incrementer stage.
REQ-007 The block SHALL have port deq_val, output, 1 bit, meaning the head entry is valid.
REQ-008 The block SHALL have port deq_rdy, input, 1 bit, meaning the consumer accepts the head.
REQ-009 The block SHALL have port deq_msg, output, p_nbits, the head value.
REQ-010 The block SHALL have port count, output, clog2(p_depth)+1 bits, the current occupancy.
REQ-011 The block SHALL have port overflow, output, 1 bit, a sticky flag meaning at least one result was dropped.

Function
REQ-012 The block SHALL behave as a FIFO: entries are dequeued in exact enqueue order with all p_nbits bits preserved; values 0x100-0x1FF are not truncated.
REQ-013 A dequeue fire SHALL occur when deq_val && deq_rdy; the enqueue accept condition is enq_val && (count < p_depth || deq fire).
REQ-014 When the queue is full and enq_val=1 in the same cycle as a deq fire, the block SHALL accept the enqueue and count SHALL stay at p_depth.
REQ-015 When enq_val=1, the queue is full and there is no deq fire, the block SHALL drop the message, leave stored entries unchanged and set overflow=1 on the next edge.
REQ-016 Once set, overflow SHALL remain 1 until reset.
REQ-017 count SHALL update on each edge as +1 for an accept only, -1 for a fire only, and unchanged for both or neither.
REQ-018 Read and write pointers SHALL wrap modulo p_depth.
REQ-019 Without bypass, an accepted entry SHALL appear on deq_msg/deq_val one cycle after the accepting edge (latency 1).
REQ-020 deq_val SHALL equal (count != 0), and deq_msg SHALL be driven 0 whenever deq_val=0.
REQ-021 deq_rdy=1 while deq_val=0 SHALL have no effect.

Reset
REQ-022 When reset=1 at an edge, the block SHALL set count=0, both pointers=0 and overflow=0; reset dominates any same-cycle enqueue or dequeue.
REQ-023 During and after reset, deq_val SHALL be 0 and deq_msg SHALL be 0; a reset mid-operation discards all stored entries.
REQ-024 Storage array contents SHALL NOT be reset.

Configuration
REQ-025 Macro TUT3_VERILOG_REGINCR_RESULT_QUEUE_BYPASS_EN SHALL control bypass: when defined, with count=0, enq_val=1 and deq_rdy=1, the block drives deq_val=1 and deq_msg=enq_msg combinationally in the same cycle, does not store the message, and leaves count unchanged.
REQ-026 With the macro defined, if count=0, enq_val=1 and deq_rdy=0, the block SHALL still drive deq_val=1 and deq_msg=enq_msg, and SHALL store the message.
REQ-027 With the macro undefined, the block SHALL have no combinational path from enq_* to deq_*.

Structure
REQ-028 Package tut3_verilog_regincr_pkg SHALL hold the message typedef (p_nbits-wide logic) and the default-depth constant.
REQ-029 Storage SHALL be one sub-module, tut3_verilog_regincr_queue_dpath (register array: one write port, one combinational read port); pointers, count and overflow live in the top level.

Verification
REQ-030 The bench SHALL cover reset: hold reset 2 cycles with enq_val=1 -> deq_val=0, count=0, overflow=0, deq_msg=0.
REQ-031 The bench SHALL cover in-order drain: with deq_rdy=0, enqueue 0x001, 0x002, 0x003 -> count=3; then set deq_rdy=1 -> deq_msg is 0x001, 0x002, 0x003 on consecutive cycles and count reaches 0.
REQ-032 The bench SHALL cover overflow: fill with 0x010-0x013, then enqueue 0x1FF with deq_rdy=0 -> count=4 and overflow=1; drain yields only 0x010-0x013 and overflow stays 1.
REQ-033 The bench SHALL cover full with simultaneous enqueue and dequeue: queue full, enq 0x0AA with deq fire -> count=4, overflow=0, and 0x0AA is dequeued last.
REQ-034 The bench SHALL cover wrap: 10 enqueue/dequeue pairs of values 0x0FE-0x107 -> order and 9-bit values intact across pointer wrap.
REQ-035 The bench SHALL cover bypass and mid-operation reset: empty queue, enq 0x0AB with deq_rdy=1 -> deq_msg=0x0AB in the same cycle with the macro, or the next cycle without it; then a reset with 2 entries stored -> count=0 and deq_val=0.
